spin_cycle_controller: RTL

Sequences the drum motor through one spin phase: soft ramp-up to the selected spin speed, a timed hold, then a controlled ramp-down to standstill. It sits between the spin-speed selector, which supplies the 11-bit target rpm, and the motor drive, which consumes the commanded speed. It also handles start, pause and abort requests from the top-level wash sequencer.

---
 rtl/spin_cycle_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spin_cycle_controller.sv
// Spin-phase sequencer: soft ramp-up to a latched target rpm, timed hold, then ramp-down to standstill.
// Handles start (edge-detected), pause and abort requests from the wash sequencer.
module spin_cycle_controller #(
    parameter logic [10:0] RAMP_STEP  = 11'd100,
    parameter int          STEP_TICKS = 4,
    parameter int          HOLD_TICKS = 16,
    parameter logic [10:0] MAX_SPEED  = 11'd1400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] target_speed,
    input  logic        pause,
    input  logic        abort,
    output logic [10:0] motor_speed,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state
);

    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD      = 3'd2,
        RAMP_DOWN = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [10:0]         speed_q, speed_d;
    logic [10:0]         target_q, target_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                start_prev;
    logic                start_edge;
    logic [11:0]         up_sum;
    logic [10:0]         up_speed;
    logic [10:0]         down_speed;

    assign start_edge = start & ~start_prev;

    // Ramp arithmetic: the up-sum is one bit wider so it can never wrap before clamping.
    assign up_sum     = {1'b0, speed_q} + {1'b0, RAMP_STEP};
    assign up_speed   = (up_sum > {1'b0, target_q}) ? target_q : up_sum[10:0];
    assign down_speed = (speed_q > RAMP_STEP) ? (speed_q - RAMP_STEP) : 11'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            speed_q    <= '0;
            target_q   <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            start_prev <= 1'b0;
        end else begin
            state_q    <= state_d;
            speed_q    <= speed_d;
            target_q   <= target_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            start_prev <= start;
        end
    end

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        target_d = target_q;
        step_d   = step_q;
        hold_d   = hold_q;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    target_d = (target_speed > MAX_SPEED) ? MAX_SPEED : target_speed;
                    step_d   = '0;
                    state_d  = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (abort) begin
                    state_d = RAMP_DOWN;
                    step_d  = '0;
                end else if (!pause) begin
                    if (speed_q == target_q) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end else if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        speed_d = up_speed;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = RAMP_DOWN;
                    step_d  = '0;
                end else if (!pause) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_DOWN;
                        step_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            // Deceleration deliberately ignores pause so the drum always comes to rest.
            RAMP_DOWN: begin
                if (speed_q == 11'd0) begin
                    state_d = DONE;
                end else if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    speed_d = down_speed;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign motor_speed = speed_q;
    assign state       = state_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule
